// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter that lets several AXIS command sources share one I2C
// write engine, holding each grant until the engine goes idle or a watchdog fires.
module i2c_cmd_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          clk,
  input  logic                          arstn,
  input  logic [NUM_REQ-1:0]            s_tvalid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_tdata,
  output logic [NUM_REQ-1:0]            s_tready,
  output logic                          m_tvalid,
  output logic [DATA_WIDTH-1:0]         m_tdata,
  input  logic                          m_tready,
  input  logic                          eng_busy,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_idx,
  output logic                          done,
  output logic                          timeout_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    OFFER     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      grant_idx_q, grant_idx_d;
  logic                  grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]      last_q, last_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic                  armed_q, armed_d;
  logic                  done_q, done_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [DATA_WIDTH-1:0] words [NUM_REQ];
  logic [IDX_W-1:0]      cand;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_found;
  logic                  wd_hit;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign words[i] = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Search starts just after the last served port and wraps modulo NUM_REQ.
  always_comb begin
    cand       = last_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = (cand == IDX_W'(NUM_REQ - 1)) ? '0 : cand + IDX_W'(1);
      if (!pick_found && s_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    wd_d          = '0;
    armed_d       = 1'b0;
    done_d        = 1'b0;
    timeout_err_d = 1'b0;
    m_tvalid      = 1'b0;
    m_tdata       = '0;
    s_tready      = '0;
    wd_hit        = WD_EN && (wd_q == WD_LAST);

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = OFFER;
        end
      end
      OFFER: begin
        m_tvalid              = s_tvalid[grant_idx_q];
        m_tdata               = words[grant_idx_q];
        s_tready[grant_idx_q] = m_tready;
        wd_d                  = wd_q + WD_W'(1);
        if (wd_hit) begin
          timeout_err_d = 1'b1;
          last_d        = grant_idx_q;
          grant_valid_d = 1'b0;
          wd_d          = '0;
          state_d       = IDLE;
        end else if (m_tvalid && m_tready) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // eng_busy can still be low in the handshake cycle, so the first
        // cycle here only arms the idle check; completion beats the watchdog.
        wd_d    = wd_q + WD_W'(1);
        armed_d = 1'b1;
        if (armed_q && !eng_busy) begin
          done_d        = 1'b1;
          last_d        = grant_idx_q;
          grant_valid_d = 1'b0;
          wd_d          = '0;
          state_d       = IDLE;
        end else if (wd_hit) begin
          timeout_err_d = 1'b1;
          last_d        = grant_idx_q;
          grant_valid_d = 1'b0;
          wd_d          = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d       = IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q       <= IDLE;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      last_q        <= IDX_W'(NUM_REQ - 1);
      wd_q          <= '0;
      armed_q       <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      last_q        <= last_d;
      wd_q          <= wd_d;
      armed_q       <= armed_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter: instance A has a 64-cycle watchdog,
// instance B has the watchdog disabled; both see the same stimulus.
module tb_i2c_cmd_arbiter;

  logic        clk;
  logic        arstn;
  logic [3:0]  s_tvalid;
  logic [63:0] s_tdata;
  logic        m_tready;
  logic        eng_busy;

  logic [3:0]  a_s_tready, b_s_tready;
  logic        a_m_tvalid, b_m_tvalid;
  logic [15:0] a_m_tdata, b_m_tdata;
  logic        a_grant_valid, b_grant_valid;
  logic [1:0]  a_grant_idx, b_grant_idx;
  logic        a_done, b_done;
  logic        a_timeout_err, b_timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  int a_hs = 0;
  int a_rdy_pulses = 0;
  int a_done_cnt = 0;
  int a_to_cnt = 0;
  int both_cnt = 0;

  i2c_cmd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(64)) u_dut_a (
    .clk(clk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(a_s_tready), .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata),
    .m_tready(m_tready), .eng_busy(eng_busy), .grant_valid(a_grant_valid),
    .grant_idx(a_grant_idx), .done(a_done), .timeout_err(a_timeout_err)
  );

  i2c_cmd_arbiter #(.NUM_REQ(4), .DATA_WIDTH(16), .TIMEOUT_CYCLES(0)) u_dut_b (
    .clk(clk), .arstn(arstn), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
    .s_tready(b_s_tready), .m_tvalid(b_m_tvalid), .m_tdata(b_m_tdata),
    .m_tready(m_tready), .eng_busy(eng_busy), .grant_valid(b_grant_valid),
    .grant_idx(b_grant_idx), .done(b_done), .timeout_err(b_timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (a_m_tvalid && m_tready) a_hs <= a_hs + 1;
    if (a_s_tready != 4'b0000) a_rdy_pulses <= a_rdy_pulses + 1;
    if (a_done) a_done_cnt <= a_done_cnt + 1;
    if (a_timeout_err) a_to_cnt <= a_to_cnt + 1;
    if ((a_done && a_timeout_err) || (b_done && b_timeout_err)) both_cnt <= both_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL tb_time_limit: simulation did not finish (got running, expected finished)");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int p, input logic [15:0] w);
    s_tdata[p*16 +: 16] = w;
  endtask

  task automatic do_reset();
    arstn    = 1'b0;
    s_tvalid = 4'b0000;
    m_tready = 1'b0;
    eng_busy = 1'b0;
    cyc();
    cyc();
    arstn = 1'b1;
  endtask

  // Engine model: accept after rdy_dly offer cycles, stay busy busy_len cycles.
  task automatic serve(input string tag, input int eidx, input logic [15:0] edata,
                       input int rdy_dly, input int busy_len);
    int   n;
    logic hold_ok;
    n = 0;
    while (a_m_tvalid !== 1'b1 && n < 50) begin
      cyc();
      n++;
    end
    chk({tag, "_offer"}, 32'(a_m_tvalid), 32'd1);
    repeat (rdy_dly) cyc();
    m_tready = 1'b1;
    #1;
    chk({tag, "_idx"}, 32'(a_grant_idx), 32'(eidx));
    chk({tag, "_data"}, 32'(a_m_tdata), 32'(edata));
    chk({tag, "_sready"}, 32'(a_s_tready), 32'(4'b0001 << eidx));
    cyc();
    m_tready = 1'b0;
    eng_busy = (busy_len > 0);
    hold_ok  = 1'b1;
    repeat (busy_len) begin
      cyc();
      if (!(a_grant_valid === 1'b1 && a_grant_idx === 2'(eidx) && a_done === 1'b0)) hold_ok = 1'b0;
    end
    chk({tag, "_hold"}, 32'(hold_ok), 32'd1);
    eng_busy = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_done"}, 32'(a_done), 32'd1);
  endtask

  initial begin
    int   hs0, rdy0, done0, to0;
    logic acc;

    arstn    = 1'b0;
    s_tvalid = 4'b0000;
    s_tdata  = 64'h0;
    m_tready = 1'b0;
    eng_busy = 1'b0;
    cyc();

    // Reset state
    chk("rst_grant_valid", 32'(a_grant_valid), 32'd0);
    chk("rst_grant_idx",   32'(a_grant_idx),   32'd0);
    chk("rst_m_tvalid",    32'(a_m_tvalid),    32'd0);
    chk("rst_m_tdata",     32'(a_m_tdata),     32'd0);
    chk("rst_s_tready",    32'(a_s_tready),    32'd0);
    chk("rst_done",        32'(a_done),        32'd0);
    chk("rst_timeout",     32'(a_timeout_err), 32'd0);
    do_reset();

    // 1: single requester on port 2, then a back-to-back second word
    hs0 = a_hs; rdy0 = a_rdy_pulses; done0 = a_done_cnt;
    set_word(2, 16'hA55A);
    s_tvalid = 4'b0100;
    cyc();
    chk("t1_grant_valid", 32'(a_grant_valid), 32'd1);
    chk("t1_grant_idx",   32'(a_grant_idx),   32'd2);
    chk("t1_m_tvalid",    32'(a_m_tvalid),    32'd1);
    chk("t1_m_tdata",     32'(a_m_tdata),     32'hA55A);
    chk("t1_sready_wait", 32'(a_s_tready),    32'd0);
    serve("t1a", 2, 16'hA55A, 2, 40);
    chk("t1_gap_idle", 32'(a_grant_valid), 32'd0);
    set_word(2, 16'h5AA5);
    cyc();
    chk("t1_regrant_valid", 32'(a_grant_valid), 32'd1);
    chk("t1_regrant_idx",   32'(a_grant_idx),   32'd2);
    serve("t1b", 2, 16'h5AA5, 0, 0);
    s_tvalid = 4'b0000;
    cyc();
    chk("t1_done_one_cycle", 32'(a_done), 32'd0);
    chk("t1_handshakes", 32'(a_hs - hs0), 32'd2);
    chk("t1_rdy_pulses", 32'(a_rdy_pulses - rdy0), 32'd2);
    chk("t1_done_count", 32'(a_done_cnt - done0), 32'd2);

    // 2: all four ports valid from reset
    do_reset();
    hs0 = a_hs;
    set_word(0, 16'h0A00); set_word(1, 16'h1A01);
    set_word(2, 16'h2A02); set_word(3, 16'h3A03);
    s_tvalid = 4'b1111;
    serve("t2g0", 0, 16'h0A00, 1, 3);
    set_word(0, 16'h0B00);
    serve("t2g1", 1, 16'h1A01, 1, 3);
    set_word(1, 16'h1B01);
    serve("t2g2", 2, 16'h2A02, 1, 3);
    set_word(2, 16'h2B02);
    serve("t2g3", 3, 16'h3A03, 1, 3);
    set_word(3, 16'h3B03);
    serve("t2g4", 0, 16'h0B00, 1, 3);
    s_tvalid = 4'b0000;
    cyc();
    chk("t2_handshakes", 32'(a_hs - hs0), 32'd5);

    // 3: port 1 waits behind port 3; then 0 beats 1
    do_reset();
    set_word(3, 16'h3C3C);
    s_tvalid = 4'b1000;
    cyc();
    chk("t3_grant3", 32'(a_grant_idx), 32'd3);
    set_word(1, 16'h1C1C);
    s_tvalid = 4'b1010;
    serve("t3p3", 3, 16'h3C3C, 1, 10);
    chk("t3_gap_idle", 32'(a_grant_valid), 32'd0);
    set_word(0, 16'h0C0C);
    s_tvalid = 4'b0011;
    cyc();
    chk("t3_next_valid", 32'(a_grant_valid), 32'd1);
    chk("t3_next_idx0",  32'(a_grant_idx),   32'd0);
    serve("t3p0", 0, 16'h0C0C, 0, 2);
    s_tvalid = 4'b0010;
    serve("t3p1", 1, 16'h1C1C, 0, 2);
    s_tvalid = 4'b0000;
    cyc();

    // 4: watchdog on A with the engine stuck busy
    done0 = a_done_cnt; to0 = a_to_cnt;
    set_word(2, 16'h4242); set_word(3, 16'h4343);
    s_tvalid = 4'b1100;
    cyc();
    chk("t4_grant2", 32'(a_grant_idx), 32'd2);
    m_tready = 1'b1;
    acc = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      cyc();
      if (i == 1) begin
        m_tready = 1'b0;
        eng_busy = 1'b1;
      end
      acc = acc | a_timeout_err | a_done;
    end
    chk("t4_no_early_pulse", 32'(acc), 32'd0);
    cyc();
    chk("t4_timeout_pulse", 32'(a_timeout_err), 32'd1);
    chk("t4_no_done",       32'(a_done),        32'd0);
    chk("t4_released",      32'(a_grant_valid), 32'd0);
    cyc();
    chk("t4_timeout_cleared", 32'(a_timeout_err), 32'd0);
    chk("t4_rotate_valid",    32'(a_grant_valid), 32'd1);
    chk("t4_rotate_idx3",     32'(a_grant_idx),   32'd3);
    chk("t4_b_no_timeout",    32'(b_timeout_err), 32'd0);

    // 5: asynchronous reset while A waits in WAIT_DONE
    m_tready = 1'b1;
    cyc();
    m_tready = 1'b0;
    chk("t5_in_wait", 32'(a_grant_valid), 32'd1);
    cyc();
    chk("t4_done_count", 32'(a_done_cnt - done0), 32'd0);
    chk("t4_to_count",   32'(a_to_cnt - to0),     32'd1);
    done0 = a_done_cnt;
    arstn = 1'b0;
    #1;
    chk("t5_rst_grant_valid", 32'(a_grant_valid), 32'd0);
    chk("t5_rst_grant_idx",   32'(a_grant_idx),   32'd0);
    chk("t5_rst_m_tvalid",    32'(a_m_tvalid),    32'd0);
    chk("t5_rst_m_tdata",     32'(a_m_tdata),     32'd0);
    chk("t5_rst_s_tready",    32'(a_s_tready),    32'd0);
    chk("t5_rst_done",        32'(a_done),        32'd0);
    chk("t5_rst_b_valid",     32'(b_grant_valid), 32'd0);
    eng_busy = 1'b0;
    set_word(0, 16'h5050); set_word(3, 16'h5353);
    s_tvalid = 4'b1001;
    cyc();
    cyc();
    arstn = 1'b1;
    cyc();
    chk("t5_first_valid", 32'(a_grant_valid), 32'd1);
    chk("t5_first_idx0",  32'(a_grant_idx),   32'd0);
    chk("t5_first_data",  32'(a_m_tdata),     32'h5050);
    chk("t5_no_done",     32'(a_done_cnt - done0), 32'd0);

    // Completion on the same cycle the watchdog would fire: done wins
    m_tready = 1'b1;
    acc = 1'b0;
    for (int i = 1; i <= 63; i++) begin
      cyc();
      if (i == 1) begin
        m_tready = 1'b0;
        eng_busy = 1'b1;
      end
      acc = acc | a_timeout_err | a_done;
    end
    chk("tie_no_early_pulse", 32'(acc), 32'd0);
    eng_busy = 1'b0;
    cyc();
    chk("tie_done",       32'(a_done),        32'd1);
    chk("tie_no_timeout", 32'(a_timeout_err), 32'd0);
    chk("tie_b_done",     32'(b_done),        32'd1);

    // 6: watchdog disabled on B, engine busy for 10000 cycles
    do_reset();
    set_word(0, 16'h6006);
    s_tvalid = 4'b0001;
    cyc();
    chk("t6_b_grant", 32'(b_grant_valid), 32'd1);
    chk("t6_b_data",  32'(b_m_tdata),     32'h6006);
    m_tready = 1'b1;
    #1;
    chk("t6_b_sready", 32'(b_s_tready), 32'd1);
    cyc();
    m_tready = 1'b0;
    s_tvalid = 4'b0000;
    eng_busy = 1'b1;
    acc = 1'b0;
    repeat (10000) begin
      cyc();
      acc = acc | b_timeout_err | b_done;
    end
    chk("t6_b_quiet",      32'(acc),           32'd0);
    chk("t6_b_still_held", 32'(b_grant_valid), 32'd1);
    eng_busy = 1'b0;
    begin
      int n;
      n = 0;
      while (b_done !== 1'b1 && n < 10) begin
        cyc();
        n++;
      end
    end
    chk("t6_b_done",       32'(b_done),        32'd1);
    chk("t6_b_no_timeout", 32'(b_timeout_err), 32'd0);
    cyc();

    chk("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
